// File: rtl/sprite_pkg.sv
// sprite_pkg: shared screen geometry, widths and shadow-register type for sprite_fetch
package sprite_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W = 10;
  localparam int PIX_IDX_W = 4;
  localparam logic [PIX_IDX_W-1:0] TRANSPARENT_IDX = 4'h0;
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic flip;
  } shadow_t;
endpackage

// File: rtl/sprite_geom.sv
// sprite_geom: scan position vs latched sprite box -> hit flag and sprite ROM address
module sprite_geom import sprite_pkg::*; #(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int ADDR_W = $clog2(SPRITE_W*SPRITE_H)
) (
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  shadow_t            sh,
  output logic               hit,
  output logic [ADDR_W-1:0]  addr
);
  logic [COORD_W:0] dx, dy, col;
  // 11-bit differences: positions left of / above the sprite wrap large and miss
  always_comb begin
    dx = {1'b0, draw_x} - {1'b0, sh.x};
    dy = {1'b0, draw_y} - {1'b0, sh.y};
    hit = (dx < (COORD_W+1)'(SPRITE_W)) && (dy < (COORD_W+1)'(SPRITE_H));
    col = sh.flip ? (COORD_W+1)'(SPRITE_W-1) - dx : dx;
    addr = hit ? ADDR_W'(int'(dy) * SPRITE_W + int'(col)) : '0;
  end
endmodule

// File: rtl/sprite_fetch.sv
// sprite_fetch: per-pixel sprite hit and ROM address, transparency-qualified palette index,
// once-per-frame sprite position latch and opaque-pixel count.
module sprite_fetch #(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int SCREEN_W = sprite_pkg::SCREEN_W,
  parameter int SCREEN_H = sprite_pkg::SCREEN_H,
  parameter logic [sprite_pkg::PIX_IDX_W-1:0] TRANSPARENT_IDX = sprite_pkg::TRANSPARENT_IDX,
  localparam int ADDR_W = $clog2(SPRITE_W*SPRITE_H)
) (
  input  logic                              vga_clk,
  input  logic                              reset,
  input  logic [sprite_pkg::COORD_W-1:0]    DrawX,
  input  logic [sprite_pkg::COORD_W-1:0]    DrawY,
  input  logic                              active,
  input  logic [sprite_pkg::COORD_W-1:0]    sprite_x,
  input  logic [sprite_pkg::COORD_W-1:0]    sprite_y,
  input  logic                              flip_h,
  output logic [ADDR_W-1:0]                 rom_addr,
  input  logic [sprite_pkg::PIX_IDX_W-1:0]  rom_q,
  output logic [sprite_pkg::PIX_IDX_W-1:0]  index,
  output logic                              pix_valid,
  output logic [ADDR_W:0]                   opaque_cnt,
  output logic                              frame_done
);
  import sprite_pkg::*;
  localparam int CNT_W = ADDR_W + 1;
  if (SCREEN_W >= (1 << COORD_W) || SCREEN_H >= (1 << COORD_W)) begin : g_screen_check
    $error("sprite_fetch: screen size does not fit the coordinate width");
  end
  shadow_t sh;
  logic latch, hit, hit_a, act_a, hit_b, act_b, v;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0] running;
  sprite_geom #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .ADDR_W(ADDR_W)) u_geom (
    .draw_x(DrawX),
    .draw_y(DrawY),
    .sh(sh),
    .hit(hit),
    .addr(addr)
  );
  always_comb begin
    latch = (DrawX == '0) && (DrawY == COORD_W'(SCREEN_H));
    v = hit_b && act_b && (rom_q != TRANSPARENT_IDX);
  end
  // hit_b/act_b line up with rom_q, which arrives one cycle after rom_addr
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      sh <= '0;
      rom_addr <= '0;
      hit_a <= 1'b0;
      act_a <= 1'b0;
      hit_b <= 1'b0;
      act_b <= 1'b0;
      pix_valid <= 1'b0;
      index <= TRANSPARENT_IDX;
      opaque_cnt <= '0;
      running <= '0;
      frame_done <= 1'b0;
    end else begin
      if (latch) sh <= '{x: sprite_x, y: sprite_y, flip: flip_h};
      rom_addr <= addr;
      hit_a <= hit;
      act_a <= active;
      hit_b <= hit_a;
      act_b <= act_a;
      pix_valid <= v;
      index <= v ? rom_q : TRANSPARENT_IDX;
      frame_done <= latch;
      if (latch) begin
        opaque_cnt <= running;
        running <= '0;
      end else if (pix_valid && !(&running)) begin
        running <= running + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_sprite_fetch.sv
// tb_sprite_fetch: table vectors, hand sequences and randomized frames vs a box/arithmetic model
module tb_sprite_fetch;
  logic vga_clk = 1'b0;
  logic reset = 1'b1;
  logic [9:0] DrawX = '0, DrawY = '0, sprite_x = '0, sprite_y = '0;
  logic active = 1'b0, flip_h = 1'b0;
  logic [9:0] rom_addr;
  logic [3:0] rom_q, index;
  logic pix_valid, frame_done;
  logic [10:0] opaque_cnt;
  logic [3:0] rom_mem [1024];

  sprite_fetch dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .active(active),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .flip_h(flip_h), .rom_addr(rom_addr),
    .rom_q(rom_q), .index(index), .pix_valid(pix_valid), .opaque_cnt(opaque_cnt),
    .frame_done(frame_done)
  );

  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) rom_q <= rom_mem[rom_addr];

  int passed = 0, total = 0, cyc = 0;
  int m_sx = 0, m_sy = 0, m_run = 0, m_opq = 0;
  bit m_flip = 0;
  int e_addr [8], e_idx [8], e_opq [8];
  bit e_v [8], e_fd [8], on_a [8], on_p [8], on_f [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
  endtask

  // One pixel clock: check outputs due now, drive inputs, advance the reference model.
  task automatic step(input int x, input int y, input bit act, input int sxin, input int syin,
                      input bit fl, input bit rst);
    int s, s1, s3, dx, dy, a;
    bit hit, v;
    @(negedge vga_clk);
    s = cyc % 8;
    if (on_a[s]) check("rom_addr", 32'(rom_addr), e_addr[s]);
    if (on_p[s]) begin
      check("pix_valid", 32'(pix_valid), 32'(e_v[s]));
      check("index", 32'(index), e_idx[s]);
    end
    if (on_f[s]) begin
      check("frame_done", 32'(frame_done), 32'(e_fd[s]));
      check("opaque_cnt", 32'(opaque_cnt), e_opq[s]);
    end
    on_a[s] = 0; on_p[s] = 0; on_f[s] = 0;
    DrawX = 10'(x); DrawY = 10'(y); active = act;
    sprite_x = 10'(sxin); sprite_y = 10'(syin); flip_h = fl; reset = rst;
    s1 = (cyc + 1) % 8;
    s3 = (cyc + 3) % 8;
    if (rst) begin
      m_sx = 0; m_sy = 0; m_flip = 0; m_run = 0; m_opq = 0;
      e_addr[s1] = 0; on_a[s1] = 1;
      for (int d = 1; d <= 3; d++) begin
        e_v[(cyc + d) % 8] = 0; e_idx[(cyc + d) % 8] = 0; on_p[(cyc + d) % 8] = 1;
      end
      e_fd[s1] = 0; e_opq[s1] = 0; on_f[s1] = 1;
    end else begin
      dx = x - m_sx;
      dy = y - m_sy;
      hit = dx >= 0 && dx < 32 && dy >= 0 && dy < 32;
      a = hit ? dy * 32 + (m_flip ? 31 - dx : dx) : 0;
      v = hit && act && rom_mem[a] != 4'h0;
      e_addr[s1] = a; on_a[s1] = 1;
      e_v[s3] = v; e_idx[s3] = v ? int'(rom_mem[a]) : 0; on_p[s3] = 1;
      if (v && m_run < 2047) m_run++;
      e_fd[s1] = (x == 0 && y == 480);
      if (x == 0 && y == 480) begin
        m_opq = m_run; m_run = 0; m_sx = sxin; m_sy = syin; m_flip = fl;
      end
      e_opq[s1] = m_opq; on_f[s1] = 1;
    end
    cyc++;
  endtask

  task automatic idle();
    step(700, 520, 0, $urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom), 0);
  endtask

  task automatic latch(input int sx, input int sy, input bit fl);
    for (int i = 0; i < 4; i++) idle();
    step(0, 480, 0, sx, sy, fl, 0);
  endtask

  task automatic probe(input int x, input int y, input bit act,
                       output int a, output int v, output int idx);
    step(x, y, act, $urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom), 0);
    idle();
    a = int'(rom_addr);
    idle();
    idle();
    v = int'(pix_valid);
    idx = int'(index);
  endtask

  task automatic expect_frame(input int cnt);
    idle();
    check("frame_pulse", 32'(frame_done), 1);
    check("frame_count", 32'(opaque_cnt), cnt);
    idle();
    check("frame_pulse_once", 32'(frame_done), 0);
  endtask

  task automatic fill(input int val);
    for (int i = 0; i < 1024; i++) rom_mem[i] = 4'(val);
  endtask

  task automatic scan(input int x0, input int x1, input int y0, input int y1, input bit en,
                      input int rst_y);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        if (!(x == 0 && y == 480))
          step(x, y, en && x < 640 && y < 480, $urandom_range(0, 1023),
               $urandom_range(0, 1023), 1'($urandom), (y == rst_y && x == x0));
  endtask

  typedef struct {
    int sx, sy; bit fl; int x, y; bit act; int rom; int ea; int ev; int ei;
  } vec_t;
  vec_t vecs [10];

  initial begin
    int a, v, idx;
    fill(0);
    vecs[0] = '{100, 50, 0, 100, 50, 1, 5, 0, 1, 5};
    vecs[1] = '{100, 50, 1, 100, 51, 1, 5, 63, 1, 5};
    vecs[2] = '{100, 50, 0, 131, 81, 1, 7, 1023, 1, 7};
    vecs[3] = '{100, 50, 0, 132, 50, 1, 7, 0, 0, 0};
    vecs[4] = '{100, 50, 0, 99, 50, 1, 7, 0, 0, 0};
    vecs[5] = '{100, 50, 0, 110, 60, 1, 0, 330, 0, 0};
    vecs[6] = '{100, 50, 0, 100, 50, 0, 5, 0, 0, 0};
    vecs[7] = '{0, 0, 1, 0, 0, 1, 9, 31, 1, 9};
    vecs[8] = '{630, 470, 0, 639, 479, 1, 3, 297, 1, 3};
    vecs[9] = '{1000, 0, 0, 5, 0, 1, 4, 0, 0, 0};

    for (int i = 0; i < 3; i++)
      step($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom),
           $urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom), 1);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_index", 32'(index), 0);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_opaque_cnt", 32'(opaque_cnt), 0);
    check("rst_frame_done", 32'(frame_done), 0);

    foreach (vecs[i]) begin
      fill(vecs[i].rom);
      latch(vecs[i].sx, vecs[i].sy, vecs[i].fl);
      probe(vecs[i].x, vecs[i].y, vecs[i].act, a, v, idx);
      check($sformatf("vec%0d_addr", i), a, vecs[i].ea);
      check($sformatf("vec%0d_valid", i), v, vecs[i].ev);
      check($sformatf("vec%0d_index", i), idx, vecs[i].ei);
    end

    fill(2);
    latch(100, 190, 0);
    step(100, 200, 1, 300, 190, 0, 0);
    for (int i = 0; i < 3; i++) step(700, 520, 0, 300, 190, 0, 0);
    check("midframe_old_pos", 32'(pix_valid), 1);
    probe(131, 210, 1, a, v, idx);
    check("midframe_old_edge", v, 1);
    probe(300, 200, 1, a, v, idx);
    check("midframe_new_ignored", v, 0);
    latch(300, 190, 0);
    probe(300, 200, 1, a, v, idx);
    check("after_latch_new_pos", v, 1);
    probe(100, 200, 1, a, v, idx);
    check("after_latch_old_gone", v, 0);

    fill(5);
    latch(100, 50, 0);
    step(100, 50, 1, 100, 50, 0, 0);
    step(700, 520, 0, 100, 50, 0, 1);
    idle();
    idle();
    check("reset_drops_inflight", 32'(pix_valid), 0);
    probe(0, 0, 1, a, v, idx);
    check("reset_shadow_origin", v, 1);
    probe(100, 50, 1, a, v, idx);
    check("reset_shadow_old_gone", v, 0);

    fill(1);
    latch(200, 200, 0);
    scan(195, 236, 198, 233, 1, -1);
    latch(620, 200, 0);
    expect_frame(1024);
    scan(615, 660, 200, 231, 1, -1);
    latch(620, 200, 0);
    expect_frame(640);
    scan(615, 660, 200, 231, 0, -1);
    latch(200, 200, 0);
    expect_frame(0);

    for (int f = 0; f < 6; f++) begin
      int sx, sy;
      for (int i = 0; i < 1024; i++)
        rom_mem[i] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      sx = $urandom_range(0, 700);
      sy = $urandom_range(0, 500);
      latch(sx, sy, 1'($urandom));
      scan(sx < 2 ? 0 : sx - 2, sx + 33 > 799 ? 799 : sx + 33,
           sy < 2 ? 0 : sy - 2, sy + 33 > 524 ? 524 : sy + 33, 1,
           f == 3 ? sy + 10 : -1);
    end
    latch(0, 0, 0);
    for (int i = 0; i < 4; i++) idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
